// File: rtl/encode_multi_if.sv
// encode_multi_if - signal bundle between a sample source and encode_multi.
//
// Handshake: the source raises start while busy is low; the encoder takes
// data/prescale on that edge and raises busy on the next cycle. busy stays
// high for the whole frame. done pulses for one cycle after each frame.
// start is ignored while busy. With continuous high at the end of a frame,
// the next frame begins in the same cycle that done is high.
//
// Signals:
//   start       source -> encoder  frame request
//   continuous  source -> encoder  restart at frame end when 1
//   data        source -> encoder  CH codes, channel i at [i*W +: W]
//   prescale    source -> encoder  ramp step period minus one
//   out         encoder -> source  per-channel encoded pulse
//   busy        encoder -> source  frame in progress
//   done        encoder -> source  end-of-frame pulse
//   run_state   encoder -> source  debug view of the FSM (1 = RUN)
//   encoded     encoder -> source  per-channel bit history, newest at LSB
//                                  (only with ENCODE_HISTORY_EN)
// Optional feature macro: ENCODE_HISTORY_EN
interface encode_multi_if #(
  parameter int CH = 4,
  parameter int W  = 8
`ifdef ENCODE_HISTORY_EN
  , parameter int HIST = 8
`endif
);
  logic              start;
  logic              continuous;
  logic [CH*W-1:0]   data;
  logic [W-1:0]      prescale;
  logic [CH-1:0]     out;
  logic              busy;
  logic              done;
  logic              run_state;
`ifdef ENCODE_HISTORY_EN
  logic [CH*HIST-1:0] encoded;

  modport master (output start, continuous, data, prescale,
                  input  out, busy, done, run_state, encoded);
  modport slave  (input  start, continuous, data, prescale,
                  output out, busy, done, run_state, encoded);
`else
  modport master (output start, continuous, data, prescale,
                  input  out, busy, done, run_state);
  modport slave  (input  start, continuous, data, prescale,
                  output out, busy, done, run_state);
`endif
endinterface

// File: rtl/encode_multi.sv
// encode_multi - multi-channel ramp-compare pulse-width encoder.
//
// Latches CH W-bit codes on start and sweeps a W-bit ramp that advances every
// prescale+1 cycles. Channel i output is high while code_i >= ramp, so the
// pulse lasts (code+1)*(prescale+1) cycles of a 2^W*(prescale+1) cycle frame.
//
// Ports:
//   CLK100MHZ  system clock
//   reset      synchronous, active-high reset
//   bus        encode_multi_if.slave (start/continuous/data/prescale in;
//              out/busy/done/run_state[/encoded] out)
// Optional feature macro: ENCODE_HISTORY_EN adds the per-channel history
// register driven onto bus.encoded.
module encode_multi #(
  parameter int CH = 4,
  parameter int W  = 8
`ifdef ENCODE_HISTORY_EN
  , parameter int HIST = 8
`endif
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  encode_multi_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  state_t          state_q, state_d;
  logic [CH*W-1:0] data_q, data_d;
  logic [W-1:0]    pre_q, pre_d;        // latched prescale
  logic [W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [W-1:0]    cnt_q, cnt_d;        // ramp value
  logic [CH-1:0]   out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            shift_en;            // a new out value is being loaded

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      pre_q     <= '0;
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      pre_q     <= pre_d;
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    pre_d     = pre_q;
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    shift_en  = 1'b0;

    case (state_q)
      IDLE: begin
        out_d  = '0;
        busy_d = 1'b0;
        if (bus.start) begin
          data_d    = bus.data;
          pre_d     = bus.prescale;
          cnt_d     = '0;
          pre_cnt_d = '0;
          out_d     = '1;             // every code is >= 0
          busy_d    = 1'b1;
          shift_en  = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (pre_cnt_q != pre_q) begin
          pre_cnt_d = pre_cnt_q + W'(1);
        end else if (cnt_q != CNT_MAX) begin
          pre_cnt_d = '0;
          cnt_d     = cnt_q + W'(1);
          for (int i = 0; i < CH; i++) begin
            out_d[i] = (data_q[i*W +: W] >= cnt_d);
          end
          shift_en  = 1'b1;
        end else begin
          // Frame end: either restart with fresh inputs or drop to IDLE.
          done_d    = 1'b1;
          pre_cnt_d = '0;
          cnt_d     = '0;
          shift_en  = 1'b1;
          if (bus.continuous) begin
            data_d = bus.data;
            pre_d  = bus.prescale;
            out_d  = '1;
          end else begin
            out_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        out_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.run_state = (state_q == RUN);

`ifdef ENCODE_HISTORY_EN
  logic [CH*HIST-1:0] hist_q;

  // Shift in the value that out takes on this edge, so the history LSB always
  // matches the out bit visible in the following cycle.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      hist_q <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < CH; i++) begin
        hist_q[i*HIST +: HIST] <= (hist_q[i*HIST +: HIST] << 1) | HIST'(out_d[i]);
      end
    end
  end

  assign bus.encoded = hist_q;
`else
  logic unused_shift;
  assign unused_shift = shift_en;
`endif

endmodule

// File: tb/tb_encode_multi.sv
module tb_encode_multi;

  localparam int CH = 4;
  localparam int W  = 8;
`ifdef ENCODE_HISTORY_EN
  localparam int HIST = 8;
`endif

  logic CLK100MHZ = 1'b0;
  logic reset     = 1'b1;

`ifdef ENCODE_HISTORY_EN
  encode_multi_if #(.CH(CH), .W(W), .HIST(HIST)) bus ();
  encode_multi #(.CH(CH), .W(W), .HIST(HIST)) dut (
`else
  encode_multi_if #(.CH(CH), .W(W)) bus ();
  encode_multi #(.CH(CH), .W(W)) dut (
`endif
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK100MHZ = ~CLK100MHZ;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_pop(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %0d, expected queue empty", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  // Samples are taken 1 time unit after the active edge.
  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // One-shot frame: start at cycle 0, watch cycles 1..F+3, scramble inputs and
  // pulse start mid-frame (must be ignored), then score widths and timing.
  task automatic run_frame(input logic [CH*W-1:0] d, input logic [W-1:0] p,
                           input int exp_w[CH], input int exp_f);
    int hi[CH];
    int shape_err, busy_n, done_n, done_cyc;
    logic [CH-1:0] done_out;
    logic done_busy;
    for (int ch = 0; ch < CH; ch++) begin
      exp_q.push_back(32'(exp_w[ch]));
      hi[ch] = 0;
    end
    exp_q.push_back(32'(exp_f));
    exp_q.push_back(32'(exp_f + 1));

    shape_err = 0; busy_n = 0; done_n = 0; done_cyc = 0;
    done_out = '1; done_busy = 1'b1;
    bus.continuous = 1'b0;
    bus.data       = d;
    bus.prescale   = p;
    bus.start      = 1'b1;
    step();
    for (int c = 1; c <= exp_f + 3; c++) begin
      if (bus.done) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc  = c;
          done_out  = bus.out;
          done_busy = bus.busy;
        end
      end
      if (bus.busy) busy_n++;
      for (int ch = 0; ch < CH; ch++) begin
        if (bus.out[ch]) begin
          if (c != hi[ch] + 1) shape_err++;
          hi[ch]++;
        end
      end
      bus.start    = (c < exp_f - 1) && ($urandom_range(0, 7) == 0);
      bus.data     = {$urandom, $urandom};
      bus.prescale = W'($urandom_range(0, 255));
      step();
    end
    bus.start = 1'b0;

    for (int ch = 0; ch < CH; ch++) check_pop($sformatf("width_ch%0d", ch), 32'(hi[ch]));
    check_pop("busy_cycles", 32'(busy_n));
    check_pop("done_cycle", 32'(done_cyc));
    check("done_count", 32'(done_n), 32'd1);
    check("pulse_shape", 32'(shape_err), 32'd0);
    check("out_at_done", 32'(done_out), 32'd0);
    check("busy_at_done", 32'(done_busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [CH*W-1:0] data;     // {ch3, ch2, ch1, ch0}
    logic [W-1:0]    prescale;
    int              exp_w[CH];
    int              exp_f;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int hi1, hi2, done_n, rd_done;
    logic [W-1:0] codes[CH];
    logic [W-1:0] p;

    bus.start = 1'b0; bus.continuous = 1'b0;
    bus.data = '0; bus.prescale = '0;

    // Code 64 / 0 / 255 / 10, prescale 0.
    vecs[0].data = {8'd10, 8'd255, 8'd0, 8'd64};
    vecs[0].prescale = 8'd0;
    vecs[0].exp_w = '{65, 1, 256, 11};
    vecs[0].exp_f = 256;
    // prescale 3 stretches each ramp step to 4 cycles.
    vecs[1].data = {8'd100, 8'd0, 8'd2, 8'd1};
    vecs[1].prescale = 8'd3;
    vecs[1].exp_w = '{8, 12, 4, 404};
    vecs[1].exp_f = 1024;
    vecs[2].data = {8'd33, 8'd200, 8'd7, 8'd128};
    vecs[2].prescale = 8'd1;
    vecs[2].exp_w = '{258, 16, 402, 68};
    vecs[2].exp_f = 512;
    // Random codes: width = (code+1)*(prescale+1), frame = 256*(prescale+1).
    p = W'($urandom_range(0, 2));
    for (int ch = 0; ch < CH; ch++) begin
      codes[ch] = W'($urandom_range(0, 255));
      vecs[3].data[ch*W +: W] = codes[ch];
      vecs[3].exp_w[ch] = (int'(codes[ch]) + 1) * (int'(p) + 1);
    end
    vecs[3].prescale = p;
    vecs[3].exp_f = 256 * (int'(p) + 1);

    // Reset state.
    repeat (3) step();
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_state", 32'(bus.run_state), 32'd0);
`ifdef ENCODE_HISTORY_EN
    check("rst_encoded", 32'(bus.encoded), 32'd0);
`endif
    reset = 1'b0;
    step();
    check("idle_out", 32'(bus.out), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].data, vecs[i].prescale, vecs[i].exp_w, vecs[i].exp_f);
      step();
    end

    // Continuous: ch0 code 10, changed to 20 mid-frame; stop after frame 2.
    exp_q.push_back(32'd11);
    exp_q.push_back(32'd21);
    exp_q.push_back(32'd2);
    hi1 = 0; hi2 = 0; done_n = 0;
    bus.continuous = 1'b1;
    bus.prescale = 8'd0;
    bus.data = {8'd5, 8'd5, 8'd5, 8'd10};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 520; c++) begin
      if (bus.done) done_n++;
      if (bus.out[0] && c <= 256) hi1++;
      if (bus.out[0] && c > 256 && c <= 512) hi2++;
      if (c == 2)   check("cont_state_run", 32'(bus.run_state), 32'd1);
      if (c == 11)  check("cont_f1_last_hi", 32'(bus.out[0]), 32'd1);
      if (c == 12)  check("cont_f1_first_lo", 32'(bus.out[0]), 32'd0);
      if (c == 257) begin
        check("cont_done_257", 32'(bus.done), 32'd1);
        check("cont_out_257", 32'(bus.out[0]), 32'd1);
        check("cont_busy_257", 32'(bus.busy), 32'd1);
      end
      if (c == 277) check("cont_f2_last_hi", 32'(bus.out[0]), 32'd1);
      if (c == 278) check("cont_f2_first_lo", 32'(bus.out[0]), 32'd0);
      if (c == 513) begin
        check("cont_done_513", 32'(bus.done), 32'd1);
        check("cont_busy_513", 32'(bus.busy), 32'd0);
      end
      if (c == 100) bus.data[0 +: W] = 8'd20;
      bus.start = (c == 50) || (c == 200) || (c == 400);
      if (c == 300) bus.continuous = 1'b0;
      step();
    end
    bus.start = 1'b0;
    check_pop("cont_f1_width", 32'(hi1));
    check_pop("cont_f2_width", 32'(hi2));
    check_pop("cont_done_count", 32'(done_n));

    // Reset mid-frame at cycle 100: abort with no done.
    rd_done = 0;
    bus.data = {8'd9, 8'd9, 8'd9, 8'd200};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 100; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_out", 32'(bus.out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    for (int c = 101; c < 110 + 260; c++) begin
      if (bus.done) rd_done++;
      if (c < 110) step();
    end
    check("abort_no_done", 32'(rd_done), 32'd0);
    run_frame({8'd3, 8'd2, 8'd1, 8'd0}, 8'd0, '{1, 2, 3, 4}, 256);
    step();

    // Reset has priority over start.
    reset = 1'b1;
    bus.start = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b0;
    check("rst_prio_busy", 32'(bus.busy), 32'd0);
    check("rst_prio_out", 32'(bus.out), 32'd0);

`ifdef ENCODE_HISTORY_EN
    // History: code 3, prescale 0 -> four ones then zeros.
    bus.data = {8'd0, 8'd0, 8'd0, 8'd3};
    bus.prescale = 8'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 260; c++) begin
      if (c == 8) check("hist_cycle8", 32'(bus.encoded[HIST-1:0]), 32'hF0);
      if (c == 257) check("hist_frame_end", 32'(bus.encoded[HIST-1:0]), 32'h00);
      step();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
